crop_scheduler: RTL and testbench
=================================

CROP_SCHEDULER -- requirements
Module: crop_scheduler

Interface
REQ-001 Parameters; the block SHALL use these names, defaults and meanings:
- IN_ROWS, 20, input frame height in pixels.
- IN_COLS, 20, input frame width in pixels.
- OUT_ROWS, 8, crop height.
- OUT_COLS, 8, crop width.
- NUM_CROPS, 3, crops per frame, range 1..16.
- TIMEOUT_CYCLES, 65535, watchdog limit.

REQ-002 Ports; the block SHALL provide exactly these:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse requesting a new frame.
- cfg_x0  in  NUM_CROPS x $clog2(IN_COLS)  requested crop column origins.
- cfg_y0  in  NUM_CROPS x $clog2(IN_ROWS)  requested crop row origins.
- cn_ap_ready  in  1  crop/normalise engine has accepted a start.
- cn_ap_done  in  1  crop/normalise engine has finished one crop.
- cn_m_tvalid, cn_m_tready  in  1 each  engine output-stream handshake (monitored only).
- err_clr  in  1  clears the sticky error flags.
- ap_start  out  1  start request to the engine.
- crop_x0  out  $clog2(IN_COLS)  active crop column origin.
- crop_y0  out  $clog2(IN_ROWS)  active crop row origin.
- crop_idx  out  $clog2(NUM_CROPS)+1  index of the active crop.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse when a frame completes.
- err_overrun, err_size, err_timeout  out  1 each  sticky error flags.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, START, RUN, DONE.
REQ-004 IDLE SHALL go to LOAD on frame_start=1; LOAD SHALL latch all cfg_x0/cfg_y0 into shadow registers, clear crop_idx, and go to START the next cycle.
REQ-005 Shadow origins SHALL be clamped when latched: x0 greater than IN_COLS-OUT_COLS becomes IN_COLS-OUT_COLS, and y0 greater than IN_ROWS-OUT_ROWS becomes IN_ROWS-OUT_ROWS.
REQ-006 crop_x0/crop_y0 SHALL be registered outputs equal to shadow[crop_idx], valid from the first START cycle onward and stable through RUN.
REQ-007 START SHALL hold ap_start=1 until the cycle cn_ap_ready=1 is sampled, then go to RUN; ap_start SHALL be 0 in every other state.
REQ-008 RUN SHALL count beats where cn_m_tvalid and cn_m_tready are both 1, using a counter of width $clog2(OUT_ROWS*OUT_COLS+1) that saturates at all-ones.
REQ-009 On cn_ap_done=1 in RUN:
- if the beat count, including a beat in that same cycle, is not OUT_ROWS*OUT_COLS, err_size SHALL be set;
- the beat counter SHALL clear;
- if crop_idx=NUM_CROPS-1 the FSM SHALL go to DONE, otherwise crop_idx SHALL increment and the FSM SHALL go to START.
REQ-010 DONE SHALL assert frame_done for exactly one cycle and go to IDLE; minimum frame_start-to-first-ap_start latency SHALL be 2 cycles.
REQ-011 busy SHALL be 1 in LOAD, START, RUN and DONE.
REQ-012 frame_start in any state other than IDLE SHALL be ignored and SHALL set err_overrun; shadow registers SHALL not change.
REQ-013 cn_ap_done outside RUN SHALL be ignored.
REQ-014 Error flags SHALL be sticky until err_clr=1; if err_clr and a set condition coincide, the set SHALL win.

Reset
REQ-015 While reset=0 the block SHALL enter IDLE, with ap_start, busy, frame_done, all error flags, crop_idx, beat counter and watchdog at 0, and shadow origins, crop_x0 and crop_y0 at 0.
REQ-016 Reset asserted mid-frame SHALL abort the frame immediately with no frame_done pulse; reset release SHALL be synchronised internally with a 2-flop deassert synchroniser.

Configuration
REQ-017 With CROP_SCHED_TIMEOUT_EN defined, a watchdog SHALL count consecutive cycles spent in START or RUN.
- It SHALL reset on every state transition.
- Reaching TIMEOUT_CYCLES SHALL set err_timeout and force the FSM to IDLE with no frame_done pulse.
REQ-018 Without CROP_SCHED_TIMEOUT_EN, no watchdog logic SHALL exist and err_timeout SHALL be tied to 0.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Nominal frame: cfg (2,3),(10,1),(5,12), engine returns 64 beats per crop. Expect 3 ap_start/ap_ready handshakes with crop_x0/crop_y0 = (2,3),(10,1),(5,12) in order, then one frame_done pulse, and no errors.
- Clamping: cfg_x0=19, cfg_y0=15. Expect crop_x0=12, crop_y0=12.
- Overrun: frame_start pulsed during RUN of crop 1. Expect err_overrun=1, crop sequence unchanged, and err_overrun cleared after err_clr.
- Size error: engine returns 63 beats for crop 0. Expect err_size=1 after that cn_ap_done; crops 1 and 2 still run.
- Mid-operation reset: reset=0 during START of crop 2. Expect all outputs 0 and no frame_done; a new frame_start after release runs normally.
- Timeout (macro defined, TIMEOUT_CYCLES=100): cn_ap_ready held at 0. Expect err_timeout=1 and busy=0 after 100 START cycles.

Source files
------------

// File: rtl/crop_scheduler.sv
// crop_scheduler: sequences NUM_CROPS crop/normalise jobs per frame.
//   On frame_start the requested crop origins are clamped and captured into
//   shadow registers. Each crop is then launched on the engine with an
//   ap_start/ap_ready handshake. The engine output stream is monitored to
//   check that each crop returns exactly OUT_ROWS*OUT_COLS beats.
//
// Optional feature: define CROP_SCHED_TIMEOUT_EN to build the START/RUN
//   watchdog. Without it, err_timeout is tied to 0.
//
// Ports:
//   clk, reset         clock; async active-low reset (release synchronised)
//   frame_start        one-cycle frame request
//   cfg_x0 / cfg_y0    per-crop requested origins
//   cn_ap_ready        engine accepted start
//   cn_ap_done         engine finished a crop
//   cn_m_tvalid/tready engine output stream handshake (monitor only)
//   err_clr            clears the sticky error flags
//   ap_start           start request to the engine
//   crop_x0 / crop_y0  origin of the active crop
//   crop_idx           index of the active crop
//   busy, frame_done   frame in progress / one-cycle completion pulse
//   err_overrun, err_size, err_timeout  sticky error flags
module crop_scheduler #(
  parameter int unsigned IN_ROWS        = 20,
  parameter int unsigned IN_COLS        = 20,
  parameter int unsigned OUT_ROWS       = 8,
  parameter int unsigned OUT_COLS       = 8,
  parameter int unsigned NUM_CROPS      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        frame_start,
  input  logic [NUM_CROPS-1:0][$clog2(IN_COLS)-1:0]   cfg_x0,
  input  logic [NUM_CROPS-1:0][$clog2(IN_ROWS)-1:0]   cfg_y0,
  input  logic                                        cn_ap_ready,
  input  logic                                        cn_ap_done,
  input  logic                                        cn_m_tvalid,
  input  logic                                        cn_m_tready,
  input  logic                                        err_clr,
  output logic                                        ap_start,
  output logic [$clog2(IN_COLS)-1:0]                  crop_x0,
  output logic [$clog2(IN_ROWS)-1:0]                  crop_y0,
  output logic [$clog2(NUM_CROPS):0]                  crop_idx,
  output logic                                        busy,
  output logic                                        frame_done,
  output logic                                        err_overrun,
  output logic                                        err_size,
  output logic                                        err_timeout
);

  localparam int unsigned XW    = $clog2(IN_COLS);
  localparam int unsigned YW    = $clog2(IN_ROWS);
  localparam int unsigned IW    = $clog2(NUM_CROPS) + 1;
  localparam int unsigned BEATS = OUT_ROWS * OUT_COLS;
  localparam int unsigned BW    = $clog2(BEATS + 1);

  localparam logic [XW-1:0] X_MAX     = XW'(IN_COLS - OUT_COLS);
  localparam logic [YW-1:0] Y_MAX     = YW'(IN_ROWS - OUT_ROWS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CROPS - 1);
  localparam logic [BW-1:0] BEATS_EXP = BW'(BEATS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  logic [XW-1:0]   r_shadow_x [NUM_CROPS];
  logic [YW-1:0]   r_shadow_y [NUM_CROPS];
  logic [XW-1:0]   r_crop_x0;
  logic [YW-1:0]   r_crop_y0;
  logic [IW-1:0]   r_crop_idx;
  logic [BW-1:0]   r_beat_cnt;
  logic            r_ap_start;
  logic            r_busy;
  logic            r_frame_done;
  logic            r_err_overrun;
  logic            r_err_size;

  logic            w_beat;
  logic [BW-1:0]   w_cnt_now;
  logic [IW-1:0]   w_next_idx;
  logic            w_set_overrun;
  logic            w_set_size;
  logic            w_wd_expire;

  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
    return (v > X_MAX) ? X_MAX : v;
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
    return (v > Y_MAX) ? Y_MAX : v;
  endfunction

  // Reset asserts asynchronously, releases two clocks after reset goes high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Beat count including any beat in the current cycle, saturating at all-ones
  assign w_beat        = cn_m_tvalid & cn_m_tready;
  assign w_cnt_now     = (w_beat && (r_beat_cnt != '1)) ? r_beat_cnt + BW'(1) : r_beat_cnt;
  assign w_next_idx    = r_crop_idx + IW'(1);
  assign w_set_overrun = frame_start && (r_state != S_IDLE);
  assign w_set_size    = (r_state == S_RUN) && cn_ap_done && (w_cnt_now != BEATS_EXP);

`ifdef CROP_SCHED_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] r_wdog;
  logic          r_err_timeout;
  logic          w_active;
  logic          w_fsm_move;

  assign w_active    = (r_state == S_START) || (r_state == S_RUN);
  assign w_fsm_move  = ((r_state == S_START) && cn_ap_ready) ||
                       ((r_state == S_RUN)   && cn_ap_done);
  assign w_wd_expire = w_active && (r_wdog == WW'(TIMEOUT_CYCLES - 1));

  // Watchdog: consecutive cycles in START/RUN, restarted on every transition
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wdog        <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_wdog <= (w_active && !w_fsm_move && !w_wd_expire) ? r_wdog + WW'(1) : '0;
      if (w_wd_expire)  r_err_timeout <= 1'b1;
      else if (err_clr) r_err_timeout <= 1'b0;
    end
  end
  assign err_timeout = r_err_timeout;
`else
  assign w_wd_expire = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Frame sequencer with registered outputs and sticky error flags
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= S_IDLE;
      r_ap_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_size    <= 1'b0;
      r_crop_idx    <= '0;
      r_beat_cnt    <= '0;
      r_crop_x0     <= '0;
      r_crop_y0     <= '0;
      for (int unsigned i = 0; i < NUM_CROPS; i++) begin
        r_shadow_x[i] <= '0;
        r_shadow_y[i] <= '0;
      end
    end else begin
      r_frame_done <= 1'b0;

      if (w_set_overrun) r_err_overrun <= 1'b1;
      else if (err_clr)  r_err_overrun <= 1'b0;

      if (w_set_size)    r_err_size <= 1'b1;
      else if (err_clr)  r_err_size <= 1'b0;

      if ((r_state == S_RUN) && !cn_ap_done) r_beat_cnt <= w_cnt_now;
      else                                   r_beat_cnt <= '0;

      if (w_wd_expire) begin
        r_state    <= S_IDLE;
        r_ap_start <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (frame_start) begin
              r_state <= S_LOAD;
              r_busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            for (int unsigned i = 0; i < NUM_CROPS; i++) begin
              r_shadow_x[i] <= clamp_x(cfg_x0[i]);
              r_shadow_y[i] <= clamp_y(cfg_y0[i]);
            end
            // Crop 0 origin goes straight to the outputs so it is valid in START
            r_crop_x0  <= clamp_x(cfg_x0[0]);
            r_crop_y0  <= clamp_y(cfg_y0[0]);
            r_crop_idx <= '0;
            r_ap_start <= 1'b1;
            r_state    <= S_START;
          end
          S_START: begin
            if (cn_ap_ready) begin
              r_ap_start <= 1'b0;
              r_state    <= S_RUN;
            end
          end
          S_RUN: begin
            if (cn_ap_done) begin
              if (r_crop_idx == LAST_IDX) begin
                r_frame_done <= 1'b1;
                r_state      <= S_DONE;
              end else begin
                r_crop_idx <= w_next_idx;
                r_crop_x0  <= r_shadow_x[w_next_idx];
                r_crop_y0  <= r_shadow_y[w_next_idx];
                r_ap_start <= 1'b1;
                r_state    <= S_START;
              end
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_ap_start <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ap_start    = r_ap_start;
  assign crop_x0     = r_crop_x0;
  assign crop_y0     = r_crop_y0;
  assign crop_idx    = r_crop_idx;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign err_overrun = r_err_overrun;
  assign err_size    = r_err_size;

endmodule

// File: tb/tb_crop_scheduler.sv
// Bench for crop_scheduler: a simple engine model serves each crop, expected
// clamped origins are queued when a frame is requested and compared when the
// scheduler launches each crop.
module tb_crop_scheduler;

  localparam int unsigned NC = 3;
  localparam int unsigned XW = 5;
  localparam int unsigned YW = 5;
  localparam int unsigned IW = 3;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    frame_start = 1'b0;
  logic [NC-1:0][XW-1:0]   cfg_x0 = '0;
  logic [NC-1:0][YW-1:0]   cfg_y0 = '0;
  logic                    cn_ap_ready = 1'b0;
  logic                    cn_ap_done = 1'b0;
  logic                    cn_m_tvalid = 1'b0;
  logic                    cn_m_tready = 1'b0;
  logic                    err_clr = 1'b0;
  logic                    ap_start;
  logic [XW-1:0]           crop_x0;
  logic [YW-1:0]           crop_y0;
  logic [IW-1:0]           crop_idx;
  logic                    busy;
  logic                    frame_done;
  logic                    err_overrun;
  logic                    err_size;
  logic                    err_timeout;

  int n_total = 0;
  int n_bad   = 0;
  int lat;
  logic [XW-1:0] q_x [$];
  logic [YW-1:0] q_y [$];

  crop_scheduler #(
    .IN_ROWS(20), .IN_COLS(20), .OUT_ROWS(8), .OUT_COLS(8),
    .NUM_CROPS(3), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0),
    .cn_ap_ready(cn_ap_ready), .cn_ap_done(cn_ap_done),
    .cn_m_tvalid(cn_m_tvalid), .cn_m_tready(cn_m_tready),
    .err_clr(err_clr), .ap_start(ap_start),
    .crop_x0(crop_x0), .crop_y0(crop_y0), .crop_idx(crop_idx),
    .busy(busy), .frame_done(frame_done),
    .err_overrun(err_overrun), .err_size(err_size), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame is 20x20, crop 8x8: both origins saturate at 12
  function automatic logic [4:0] clampv(input int v);
    return (v > 12) ? 5'd12 : 5'(v);
  endfunction

  task automatic start_frame(input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2);
    cfg_x0[0] = 5'(x0); cfg_y0[0] = 5'(y0);
    cfg_x0[1] = 5'(x1); cfg_y0[1] = 5'(y1);
    cfg_x0[2] = 5'(x2); cfg_y0[2] = 5'(y2);
    q_x.push_back(clampv(x0)); q_y.push_back(clampv(y0));
    q_x.push_back(clampv(x1)); q_y.push_back(clampv(y1));
    q_x.push_back(clampv(x2)); q_y.push_back(clampv(y2));
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_ap(output int cyc);
    cyc = 0;
    while (ap_start !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (ap_start !== 1'b1) check("ap_start_wait", 0, 1);
  endtask

  task automatic check_origin(output logic [XW-1:0] ex);
    logic [YW-1:0] ey;
    ex = '0;
    if (q_x.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      ex = q_x.pop_front();
      ey = q_y.pop_front();
      check("crop_x0", crop_x0, ex);
      check("crop_y0", crop_y0, ey);
    end
  endtask

  // Engine model: accept start, one stalled beat, `beats` real beats, then done
  task automatic serve_crop(input int idx, input int beats, input bit fs_pulse, output int cyc);
    logic [XW-1:0] ex;
    wait_ap(cyc);
    check_origin(ex);
    check("crop_idx", crop_idx, idx);
    check("busy_start", busy, 1);
    cn_ap_ready = 1'b1;
    @(negedge clk);
    cn_ap_ready = 1'b0;
    check("ap_start_run", ap_start, 0);
    cn_m_tvalid = 1'b1; cn_m_tready = 1'b0;
    @(negedge clk);
    for (int b = 0; b < beats; b++) begin
      cn_m_tvalid = 1'b1; cn_m_tready = 1'b1;
      if (fs_pulse && b == 10) begin
        frame_start = 1'b1;
        cfg_x0 = {5'd7, 5'd7, 5'd7};
        cfg_y0 = {5'd7, 5'd7, 5'd7};
      end else begin
        frame_start = 1'b0;
      end
      @(negedge clk);
    end
    cn_m_tvalid = 1'b0; cn_m_tready = 1'b0; frame_start = 1'b0;
    check("x0_hold", crop_x0, ex);
    cn_ap_done = 1'b1;
    @(negedge clk);
    cn_ap_done = 1'b0;
  endtask

  task automatic frame_end_check();
    check("frame_done", frame_done, 1);
    @(negedge clk);
    check("frame_done_1cyc", frame_done, 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ap_start"}, ap_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_errs"}, {err_overrun, err_size, err_timeout}, 0);
    check({tag, "_crop_idx"}, crop_idx, 0);
    check({tag, "_crop_xy"}, {crop_x0, crop_y0}, 0);
  endtask

  initial begin
    logic [XW-1:0] ex;
    int cnt;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Nominal frame
    start_frame(2, 3, 10, 1, 5, 12);
    serve_crop(0, 64, 1'b0, lat);
    check("latency", lat + 1, 2);
    serve_crop(1, 64, 1'b0, lat);
    serve_crop(2, 64, 1'b0, lat);
    frame_end_check();
    check("nominal_errs", {err_overrun, err_size, err_timeout}, 0);

    // Clamping
    start_frame(19, 15, 12, 12, 0, 0);
    serve_crop(0, 64, 1'b0, lat);
    serve_crop(1, 64, 1'b0, lat);
    serve_crop(2, 64, 1'b0, lat);
    frame_end_check();

    // Overrun during RUN of crop 1; shadows must keep the original origins
    start_frame(1, 2, 3, 4, 5, 6);
    serve_crop(0, 64, 1'b0, lat);
    check("overrun_before", err_overrun, 0);
    serve_crop(1, 64, 1'b1, lat);
    check("overrun_set", err_overrun, 1);
    serve_crop(2, 64, 1'b0, lat);
    frame_end_check();
    check("overrun_sticky", err_overrun, 1);
    pulse_clr();
    check("overrun_clr", err_overrun, 0);

    // Short crop 0 raises err_size; remaining crops still run
    start_frame(4, 4, 8, 8, 12, 0);
    serve_crop(0, 63, 1'b0, lat);
    check("size_set", err_size, 1);
    serve_crop(1, 64, 1'b0, lat);
    serve_crop(2, 64, 1'b0, lat);
    frame_end_check();
    check("size_sticky", err_size, 1);
    pulse_clr();
    check("size_clr", err_size, 0);

    // Reset during START of crop 2
    start_frame(3, 5, 7, 9, 11, 2);
    serve_crop(0, 64, 1'b0, lat);
    serve_crop(1, 64, 1'b0, lat);
    wait_ap(lat);
    check_origin(ex);
    check("abort_idx", crop_idx, 2);
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (frame_done === 1'b1) cnt++;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (frame_done === 1'b1) cnt++;
    end
    check("midreset_no_done", cnt, 0);
    check("midreset_idle", busy, 0);

    start_frame(6, 6, 13, 2, 0, 20);
    serve_crop(0, 64, 1'b0, lat);
    check("latency_after_reset", lat + 1, 2);
    serve_crop(1, 64, 1'b0, lat);
    serve_crop(2, 64, 1'b0, lat);
    frame_end_check();
    check("after_reset_errs", {err_overrun, err_size, err_timeout}, 0);

`ifdef CROP_SCHED_TIMEOUT_EN
    // Engine never accepts: watchdog aborts after 100 START cycles
    start_frame(1, 1, 1, 1, 1, 1);
    wait_ap(lat);
    cnt = 0;
    while (ap_start === 1'b1 && cnt < 200) begin
      cnt++;
      if (frame_done === 1'b1) check("timeout_frame_done", frame_done, 0);
      @(negedge clk);
    end
    check("timeout_cycles", cnt, 100);
    check("timeout_flag", err_timeout, 1);
    check("timeout_busy", busy, 0);
    check("timeout_no_done", frame_done, 0);
    q_x.delete();
    q_y.delete();
    pulse_clr();
    check("timeout_clr", err_timeout, 0);
`else
    check("timeout_tied", err_timeout, 0);
`endif

    check("sb_drained", q_x.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
